conv_frame_encoder: RTL and testbench
=====================================

Name: conv_frame_encoder

Overview:
- Rate-1/2, K=3 convolutional encoder that sits directly upstream of the Viterbi decoder and produces the 2-bit symbol stream the decoder consumes.
- Buffers a frame of up to MAX_BITS information bits, then on a start command streams encoded symbols out over a valid/ready handshake.
- Appends optional zero tail bits to flush the encoder state.
- Supports single-symbol error injection for decoder stress testing.

Parameters:
- MAX_BITS, 32, frame buffer depth in information bits.
- G0, 3'b111, generator polynomial for sym[1]; bit 0 taps the newest input bit.
- G1, 3'b101, generator polynomial for sym[0].
- TAIL_EN, 1, when 1 append K-1=2 zero-input tail symbols after the frame.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  information bit offered.
- in_bit  in  1  information bit; bit 0 of the frame is loaded first.
- in_ready  out  1  block accepts a bit.
- start  in  1  one-cycle pulse: begin encoding the buffered frame.
- err_en  in  1  enable error injection; sampled at start.
- err_idx  in  6  symbol index to corrupt; sampled at start.
- err_mask  in  2  XOR mask applied to the corrupted symbol; sampled at start.
- sym_valid  out  1  symbol available.
- sym_data  out  2  encoded symbol, {G0 parity, G1 parity}.
- sym_ready  in  1  downstream accepts the symbol.
- bit_count  out  6  number of bits currently buffered.
- busy  out  1  high in ENCODE or TAIL.
- frame_done  out  1  one-cycle pulse after the last symbol is accepted.

Behaviour:
- Reset: state=LOAD, count=0, idx=0, enc_state=2'b00, error latch cleared. Outputs: in_ready=1, sym_valid=0, sym_data=0, busy=0, frame_done=0, bit_count=0. Reset overrides everything, including mid-frame; a partially sent frame is discarded and no frame_done is issued.
- States: LOAD, ENCODE, TAIL, DONE.
- LOAD:
  - in_ready = (count < MAX_BITS).
  - On in_valid && in_ready: buf[count] <= in_bit, count++.
  - When count==MAX_BITS, in_ready=0 and further bits are dropped.
  - start with count==0 is ignored.
  - start with count>0: go to ENCODE; idx<=0, enc_state<=0; latch err_en, err_idx, err_mask.
  - If start and in_valid occur in the same cycle, start wins and the bit is not accepted (in_ready is already 0 the following cycle).
- Encode function, with b the current input bit:
  - r = {enc_state, b}.
  - sym[1] = ^(r & G0); sym[0] = ^(r & G1).
  - On acceptance: enc_state <= {enc_state[0], b}.
- ENCODE:
  - sym_valid=1 and sym_data = encode(buf[idx]), XORed with err_mask when the latched err_en=1 and symbol index == err_idx.
  - sym_data is a function of registered state only and is stable while sym_valid && !sym_ready.
  - On sym_valid && sym_ready: update enc_state, idx++.
  - Acceptance of symbol count-1 moves to TAIL if TAIL_EN, else to DONE.
- TAIL:
  - Emits 2 symbols with b=0 under the same handshake.
  - The symbol index continues counting (count, count+1), so error injection can target tail symbols.
  - After the 2nd tail symbol is accepted, go to DONE.
- DONE (one cycle):
  - frame_done=1, sym_valid=0.
  - count<=0, then return to LOAD; in_ready=1 on the next cycle.
- A symbol transfers only on a cycle with sym_valid && sym_ready. Zero-bubble back-to-back transfers are required when sym_ready is held high.
- busy=1 in ENCODE and TAIL.
- start outside LOAD is ignored.
- bit_count reflects count and is frozen during ENCODE and TAIL.
- err_idx greater than or equal to the total symbol count: no corruption occurs.

Test Plan:
- Load bits 1,0,0,0,0,0,0,0 (frame 8'b00000001), start, sym_ready=1 -> symbols 11,10,11,00,00,00,00,00, tail 00,00, frame_done pulse after 10 transfers, busy low afterwards.
- Load 8 ones, start -> symbols 11,01,10,10,10,10,10,10, tail 01,11; first symbol appears the cycle after start; 10 consecutive transfers with no bubbles.
- All-zeros 8 bits, err_en=1, err_idx=2, err_mask=2'b01 -> symbol 2 = 01, all others 00; err_idx=40 -> no corruption.
- Backpressure: toggle sym_ready 0/1 every cycle on the all-ones frame -> identical symbol sequence, sym_data held constant across stalled cycles, total 10 transfers.
- Load 33 bits -> in_ready drops after 32, bit_count=32, 33rd bit dropped; start -> 34 symbols. start with count=0 -> no sym_valid, busy stays 0.
- Assert rst during ENCODE after 3 symbols -> next cycle sym_valid=0, in_ready=1, bit_count=0, no frame_done; a fresh 8-bit frame then encodes correctly from enc_state 00.

Source files
------------

// File: rtl/conv_frame_encoder.sv
// Rate-1/2, K=3 convolutional frame encoder feeding the Viterbi decoder.
// Buffers up to MAX_BITS bits, then streams {G0,G1} parity symbols with optional tail and error injection.
module conv_frame_encoder #(
    parameter int         MAX_BITS = 32,
    parameter logic [2:0] G0       = 3'b111,
    parameter logic [2:0] G1       = 3'b101,
    parameter bit         TAIL_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    input  logic       start,
    input  logic       err_en,
    input  logic [5:0] err_idx,
    input  logic [1:0] err_mask,
    output logic       sym_valid,
    output logic [1:0] sym_data,
    input  logic       sym_ready,
    output logic [5:0] bit_count,
    output logic       busy,
    output logic       frame_done
);

    localparam int         AW      = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [5:0] MAX_CNT = 6'(MAX_BITS);

    // Handshakes: a bit transfers on in_valid && in_ready, a symbol on
    // sym_valid && sym_ready; valid never depends on ready on either side.
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ENCODE = 2'd1,
        TAIL   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [MAX_BITS-1:0] frame_buf;
    logic [5:0]          count;
    logic [5:0]          idx;
    logic [1:0]          enc_state;
    logic                err_en_q;
    logic [5:0]          err_idx_q;
    logic [1:0]          err_mask_q;

    logic       start_go;
    logic       cur_bit;
    logic [2:0] reg_r;
    logic [1:0] sym_raw;

    assign start_go  = (state == LOAD) && start && (count != 6'd0);
    assign bit_count = count;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        sym_valid  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        cur_bit    = 1'b0;
        case (state)
            LOAD: begin
                // start takes priority: a bit offered alongside start is refused
                in_ready = (count < MAX_CNT) && !start_go;
                if (start_go) state_next = ENCODE;
            end
            ENCODE: begin
                sym_valid = 1'b1;
                busy      = 1'b1;
                cur_bit   = frame_buf[idx[AW-1:0]];
                if (sym_ready && (idx == count - 6'd1))
                    state_next = TAIL_EN ? TAIL : DONE;
            end
            TAIL: begin
                sym_valid = 1'b1;
                busy      = 1'b1;
                if (sym_ready && (idx == count + 6'd1)) state_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // Symbols come only from registered state, so they hold steady under backpressure.
    always_comb begin
        reg_r   = {enc_state, cur_bit};
        sym_raw = {^(reg_r & G0), ^(reg_r & G1)};
        if (!sym_valid)
            sym_data = 2'b00;
        else if (err_en_q && (idx == err_idx_q))
            sym_data = sym_raw ^ err_mask_q;
        else
            sym_data = sym_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            count      <= 6'd0;
            idx        <= 6'd0;
            enc_state  <= 2'b00;
            err_en_q   <= 1'b0;
            err_idx_q  <= 6'd0;
            err_mask_q <= 2'b00;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    if (start_go) begin
                        idx        <= 6'd0;
                        enc_state  <= 2'b00;
                        err_en_q   <= err_en;
                        err_idx_q  <= err_idx;
                        err_mask_q <= err_mask;
                    end else if (in_valid && in_ready) begin
                        frame_buf[count[AW-1:0]] <= in_bit;
                        count                    <= count + 6'd1;
                    end
                end
                ENCODE, TAIL: begin
                    if (sym_valid && sym_ready) begin
                        enc_state <= {enc_state[0], cur_bit};
                        idx       <= idx + 6'd1;
                    end
                end
                DONE: count <= 6'd0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Scoreboard bench for conv_frame_encoder: expected symbols are queued at start
// and compared as each symbol transfers.
module tb_conv_frame_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       start;
    logic       err_en;
    logic [5:0] err_idx;
    logic [1:0] err_mask;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic [5:0] bit_count;
    logic       busy;
    logic       frame_done;

    conv_frame_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .start(start), .err_en(err_en), .err_idx(err_idx), .err_mask(err_mask),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .bit_count(bit_count), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int         checks     = 0;
    int         failures   = 0;
    int         xfer_cnt   = 0;
    int         done_cnt   = 0;
    int         ready_mode = 0;
    logic [1:0] exp_q[$];
    logic       held_v     = 1'b0;
    logic [1:0] held_d     = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: shift register s1 (previous bit), s2 (bit before).
    task automatic push_model(input logic [63:0] bits, input int n, input logic e,
                              input logic [5:0] ei, input logic [1:0] em);
        logic s1, s2, b;
        logic [1:0] sym;
        s1 = 1'b0;
        s2 = 1'b0;
        for (int k = 0; k < n + 2; k++) begin
            b   = (k < n) ? bits[k] : 1'b0;
            sym = {b ^ s1 ^ s2, b ^ s2};
            if (e && (k == int'(ei))) sym = sym ^ em;
            exp_q.push_back(sym);
            s2 = s1;
            s1 = b;
        end
    endtask

    task automatic load_bits(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic pulse_start(input logic e, input logic [5:0] ei, input logic [1:0] em);
        start    = 1'b1;
        err_en   = e;
        err_idx  = ei;
        err_mask = em;
        @(posedge clk);
        #1;
        start    = 1'b0;
        err_en   = 1'b0;
        err_idx  = 6'd0;
        err_mask = 2'b00;
    endtask

    task automatic wait_done(input int d0, input int x0, input int nsym);
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > d0) break;
            @(negedge clk);
        end
        check("frame_done_seen", done_cnt, d0 + 1);
        check("xfer_total", xfer_cnt - x0, nsym);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("busy_after", busy, 1'b0);
        check("done_pulse", frame_done, 1'b0);
        exp_q.delete();
    endtask

    // sym_ready driver: 0 = held high, 1 = toggle each cycle, 2 = random
    initial begin
        sym_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       sym_ready = ~sym_ready;
                2:       sym_ready = 1'($urandom_range(0, 1));
                default: sym_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compare each transfer against the queue, check stall stability
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v && sym_valid) check("stall_hold", sym_data, held_d);
                if (sym_valid && sym_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) check("unexpected_sym", exp_q.size(), 1);
                    else check("sym", sym_data, exp_q.pop_front());
                end
                held_v = sym_valid && !sym_ready;
                held_d = sym_data;
                if (frame_done) begin
                    done_cnt++;
                    check("done_after_last", exp_q.size(), 0);
                end
            end
        end
    end

    initial begin
        logic [63:0] v;
        int d0, x0;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; start = 1'b0;
        err_en = 1'b0; err_idx = 6'd0; err_mask = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_sym_valid", sym_valid, 1'b0);
        check("rst_sym_data", sym_data, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_bit_count", bit_count, 6'd0);

        // Single one: known impulse response plus tail
        load_bits(64'h01, 8);
        check("count_8", bit_count, 6'd8);
        exp_q = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(1'b0, 6'd0, 2'b00);
        wait_done(d0, x0, 10);

        // All ones, ready held high: no bubbles, done right after the 10th transfer
        load_bits(64'hFF, 8);
        exp_q = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(1'b0, 6'd0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_bubble", sym_valid, 1'b1);
            check("busy_enc", busy, 1'b1);
        end
        @(negedge clk);
        check("done_at_11", frame_done, 1'b1);
        wait_done(d0, x0, 10);

        // Error injection on symbol 2, then out of range, then on a tail symbol
        load_bits(64'h0, 8);
        exp_q = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(1'b1, 6'd2, 2'b01);
        wait_done(d0, x0, 10);

        load_bits(64'h0, 8);
        push_model(64'h0, 8, 1'b1, 6'd40, 2'b11);
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(1'b1, 6'd40, 2'b11);
        wait_done(d0, x0, 10);

        v = 64'($urandom);
        load_bits(v, 8);
        push_model(v, 8, 1'b1, 6'd9, 2'b11);
        ready_mode = 2;
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(1'b1, 6'd9, 2'b11);
        wait_done(d0, x0, 10);

        // Backpressure: toggling ready on the all-ones frame
        load_bits(64'hFF, 8);
        push_model(64'hFF, 8, 1'b0, 6'd0, 2'b00);
        ready_mode = 1;
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(1'b0, 6'd0, 2'b00);
        wait_done(d0, x0, 10);

        // Overfill: 33rd bit dropped, 34 symbols out
        ready_mode = 2;
        v = {32'($urandom), 32'($urandom)};
        load_bits(v, 33);
        check("full_count", bit_count, 6'd32);
        check("full_in_ready", in_ready, 1'b0);
        push_model(v, 32, 1'b0, 6'd0, 2'b00);
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(1'b0, 6'd0, 2'b00);
        wait_done(d0, x0, 34);

        // start with an empty buffer is ignored
        d0 = done_cnt;
        pulse_start(1'b0, 6'd0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("empty_start_valid", sym_valid, 1'b0);
            check("empty_start_busy", busy, 1'b0);
        end
        check("empty_start_done", done_cnt, d0);
        @(posedge clk);
        #1;

        // Reset mid-frame after 3 symbols, then a clean frame
        ready_mode = 0;
        v = 64'($urandom);
        load_bits(v, 8);
        push_model(v, 8, 1'b0, 6'd0, 2'b00);
        d0 = done_cnt;
        pulse_start(1'b0, 6'd0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_sym_valid", sym_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_bit_count", bit_count, 6'd0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, d0);
        v = 64'($urandom);
        load_bits(v, 8);
        push_model(v, 8, 1'b0, 6'd0, 2'b00);
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(1'b0, 6'd0, 2'b00);
        wait_done(d0, x0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
